// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master shift engine: FSM state encoding
// and the default word and divider widths.
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int SPI_DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period counter: counts 0..hdiv, flags the first and last cycle of
// each phase, and restarts from zero on load or on its own terminal tick.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] hdiv,
    output logic             tick,
    output logic             first
);

    logic [DIV_W-1:0] cnt;

    assign tick  = (cnt == hdiv);
    assign first = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master word engine between a FWFT TX FIFO and an RX FIFO; shifts
// MSB-first on mosi while capturing miso, holding cs_n low across back-to-back words.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_exists,
    output logic             tx_read,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_write,
    input  logic             rx_full,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sh;
    logic [DIV_W-1:0] hdiv;
    logic [CNT_W-1:0] bitcnt;
    logic             rbit;
    logic             rbit_now;
    logic             start;
    logic             div_load;
    logic             tick;
    logic             first;

    spi_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .load  (div_load),
        .hdiv  (hdiv),
        .tick  (tick),
        .first (first)
    );

    always_comb begin
        start      = ((state == IDLE) || (state == DONE)) && enable && tx_exists && !rx_full;
        // With a one-cycle half period the sample and the shift share a cycle.
        rbit_now   = first ? miso : rbit;
        div_load   = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                div_load = 1'b1;
                if (start) state_next = SETUP;
            end
            SETUP: if (tick) state_next = HIGH;
            HIGH:  if (tick) state_next = LOW;
            LOW: begin
                if (tick) state_next = (bitcnt == CNT_W'(WIDTH)) ? DONE : HIGH;
            end
            DONE: begin
                div_load   = 1'b1;
                state_next = start ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_read = start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            rx_write <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            sh       <= '0;
            hdiv     <= '0;
            bitcnt   <= '0;
            rbit     <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            rx_write <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh     <= tx_data;
                        hdiv   <= clk_div;
                        bitcnt <= '0;
                        cs_n   <= 1'b0;
                        sck    <= 1'b0;
                        mosi   <= tx_data[WIDTH-1];
                    end else begin
                        cs_n   <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) sck <= 1'b1;
                end
                HIGH: begin
                    if (first) rbit <= miso;
                    if (tick) begin
                        sck    <= 1'b0;
                        sh     <= {sh[WIDTH-2:0], rbit_now};
                        mosi   <= sh[WIDTH-2];
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (bitcnt == CNT_W'(WIDTH)) begin
                            rx_write <= 1'b1;
                            rx_data  <= sh;
                        end else begin
                            sck      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: FWFT TX FIFO model, loopback miso,
// and an event log sampled on the falling clock edge.
module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       rx_full = 1'b0;
    logic       tx_exists = 1'b0;
    logic       loop = 1'b1;
    logic       miso_fix = 1'b0;
    logic [7:0] clk_div = 8'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_read, rx_write, sck, mosi, cs_n, busy;
    logic [7:0] rx_data;
    logic       miso;

    assign miso = loop ? mosi : miso_fix;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int         q_rd[$], q_wr[$], q_csf[$], q_csr[$], q_rise[$], q_fall[$];
    logic [7:0] q_wd[$];
    logic       q_mosi[$];
    logic [7:0] tx_words[$];
    logic       p_sck = 1'b0;
    logic       p_cs = 1'b1;

    int brd, bwr, bcf, bcr, brs, bfl;

    spi_shift_engine #(.WIDTH(8), .DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clk_div   (clk_div),
        .tx_data   (tx_data),
        .tx_exists (tx_exists),
        .tx_read   (tx_read),
        .rx_data   (rx_data),
        .rx_write  (rx_write),
        .rx_full   (rx_full),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // FWFT FIFO: head index equals the number of reads seen so far.
    always @(posedge clk) begin
        #1;
        tx_exists = (tx_words.size() > q_rd.size());
        if (tx_words.size() > q_rd.size()) tx_data = tx_words[q_rd.size()];
    end

    always @(negedge clk) begin
        if (tx_read) q_rd.push_back(cyc);
        if (rx_write) begin
            q_wr.push_back(cyc);
            q_wd.push_back(rx_data);
        end
        if (sck && !p_sck) begin
            q_rise.push_back(cyc);
            q_mosi.push_back(mosi);
        end
        if (!sck && p_sck) q_fall.push_back(cyc);
        if (!cs_n && p_cs) q_csf.push_back(cyc);
        if (cs_n && !p_cs) q_csr.push_back(cyc);
        p_sck = sck;
        p_cs  = cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic mark();
        brd = q_rd.size();
        bwr = q_wr.size();
        bcf = q_csf.size();
        bcr = q_csr.size();
        brs = q_rise.size();
        bfl = q_fall.size();
    endtask

    initial begin
        int         c0, n;
        int         nr;
        logic       ps;
        logic [7:0] b;

        // Asynchronous reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_tx_read", tx_read, 0);
        chk("rst_rx_write", rx_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_mosi", mosi, 0);
        step(2);
        rst = 1'b0;
        step(2);

        // Single word A5, clk_div=0, loopback
        mark();
        clk_div = 8'd0;
        enable  = 1'b1;
        c0 = cyc;
        tx_words.push_back(8'hA5);
        step(30);
        chk("s_rd_cnt", q_rd.size() - brd, 1);
        n = q_rd[brd];
        chk("s_rd_cyc", n, c0 + 1);
        chk("s_csf", q_csf[bcf], n + 1);
        chk("s_rise_cnt", q_rise.size() - brs, 8);
        chk("s_rise0", q_rise[brs], n + 2);
        chk("s_rise7", q_rise[brs+7], n + 16);
        chk("s_high_len", q_fall[bfl] - q_rise[brs], 1);
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], q_mosi[brs+i]};
        chk("s_mosi_seq", b, 8'hA5);
        chk("s_wr_cnt", q_wr.size() - bwr, 1);
        chk("s_wr_cyc", q_wr[bwr], n + 18);
        chk("s_wr_data", q_wd[bwr], 8'hA5);
        chk("s_csr", q_csr[bcr], n + 19);
        chk("s_busy_end", busy, 0);

        // Back-to-back 01, 80, FF with clk_div=2
        mark();
        clk_div = 8'd2;
        tx_words.push_back(8'h01);
        tx_words.push_back(8'h80);
        tx_words.push_back(8'hFF);
        step(190);
        chk("b_rd_cnt", q_rd.size() - brd, 3);
        chk("b_wr_cnt", q_wr.size() - bwr, 3);
        chk("b_lat0", q_wr[bwr] - q_rd[brd], 52);
        chk("b_gap1", q_wr[bwr+1] - q_wr[bwr], 52);
        chk("b_gap2", q_wr[bwr+2] - q_wr[bwr+1], 52);
        chk("b_rd1_eq_wr0", q_rd[brd+1], q_wr[bwr]);
        chk("b_rd2_eq_wr1", q_rd[brd+2], q_wr[bwr+1]);
        chk("b_data0", q_wd[bwr], 8'h01);
        chk("b_data1", q_wd[bwr+1], 8'h80);
        chk("b_data2", q_wd[bwr+2], 8'hFF);
        chk("b_csf_cnt", q_csf.size() - bcf, 1);
        chk("b_csr_cnt", q_csr.size() - bcr, 1);
        chk("b_csr_cyc", q_csr[bcr], q_wr[bwr+2] + 1);

        // Backpressure via rx_full
        mark();
        clk_div = 8'd0;
        rx_full = 1'b1;
        tx_words.push_back(8'h3A);
        step(5);
        chk("bp_no_read", q_rd.size() - brd, 0);
        chk("bp_busy", busy, 0);
        chk("bp_exists", tx_exists, 1);
        rx_full = 1'b0;
        c0 = cyc;
        step(25);
        chk("bp_rd_cyc", q_rd[brd], c0);
        chk("bp_wr_data", q_wd[bwr], 8'h3A);

        // enable cleared mid-word
        mark();
        tx_words.push_back(8'h3C);
        tx_words.push_back(8'h5A);
        step(7);
        enable = 1'b0;
        step(40);
        chk("en_rd_cnt", q_rd.size() - brd, 1);
        chk("en_wr_cnt", q_wr.size() - bwr, 1);
        chk("en_wr_data", q_wd[bwr], 8'h3C);
        chk("en_busy", busy, 0);
        chk("en_cs_n", cs_n, 1);
        chk("en_exists", tx_exists, 1);
        enable = 1'b1;
        step(25);
        chk("en_resume_data", q_wd[bwr+1], 8'h5A);

        // Reset at the 4th sck rise
        mark();
        tx_words.push_back(8'h77);
        nr = 0;
        ps = sck;
        for (int i = 0; i < 60 && nr < 4; i++) begin
            step(1);
            if (sck && !ps) nr = nr + 1;
            ps = sck;
        end
        chk("r_reach_rise4", nr, 4);
        rst = 1'b1;
        #1;
        chk("r_cs_n", cs_n, 1);
        chk("r_sck", sck, 0);
        chk("r_busy", busy, 0);
        chk("r_rx_write", rx_write, 0);
        step(1);
        rst = 1'b0;
        step(30);
        chk("r_no_write", q_wr.size() - bwr, 0);
        chk("r_idle_cs_n", cs_n, 1);
        mark();
        tx_words.push_back(8'h99);
        step(30);
        chk("r_next_rd_cnt", q_rd.size() - brd, 1);
        n = q_rd[brd];
        chk("r_next_csf", q_csf[bcf], n + 1);
        chk("r_next_rise0", q_rise[brs], n + 2);
        chk("r_next_wr_cyc", q_wr[bwr], n + 18);
        chk("r_next_data", q_wd[bwr], 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
